// File: rtl/fir_pkg.sv
// Shared constants for the FIR output path: sample width, FIFO depth and the
// decimation-field width, plus the FIFO fill-level width helper.
package fir_pkg;

   localparam int FIR_DW         = 16;
   localparam int FIR_FIFO_DEPTH = 8;
   localparam int FIR_DECIM_W    = 4;

   // One extra bit so that a completely full FIFO (level == DEPTH) can be represented.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/tqvp_vibhee_sync_fifo.sv
// Generic single-clock DW x DEPTH FIFO. Full/empty come from the level count;
// the pointers wrap naturally at DEPTH.
module tqvp_vibhee_sync_fifo
   import fir_pkg::*;
#(
   parameter int DW    = FIR_DW,
   parameter int DEPTH = FIR_FIFO_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [DW-1:0]               wr_data,
   input  logic                        rd_en,
   output logic [DW-1:0]               rd_data,
   output logic [level_w(DEPTH)-1:0]   level,
   output logic                        full,
   output logic                        empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_w(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          wr_ok;
   logic          rd_ok;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);

   // A write into a full FIFO is only legal when the head leaves in the same cycle.
   assign rd_ok = rd_en && !empty;
   assign wr_ok = wr_en && (!full || rd_ok);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_ok) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_ok, rd_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign level   = level_q;

endmodule

// File: rtl/tqvp_vibhee_fir_out_fifo.sv
// FIR output stage: keeps 1 of every (decim+1) results, buffers them in a small
// FIFO for the readout logic and flags kept samples lost to a full FIFO.
module tqvp_vibhee_fir_out_fifo
   import fir_pkg::*;
#(
   parameter int DEPTH = FIR_FIFO_DEPTH,
   parameter int DW    = FIR_DW,
   parameter int CW    = FIR_DECIM_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DW-1:0]               in_data,
   input  logic                        in_valid,
   input  logic [CW-1:0]               decim,
   input  logic                        clr_ovf,
   output logic [DW-1:0]               out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [level_w(DEPTH)-1:0]   level,
   output logic                        overflow
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          seen_q, seen_d;
   logic          ovf_q, ovf_d;
   logic          keep;
   logic          push;
   logic          pop;
   logic          drop;
   logic          fifo_full;
   logic          fifo_empty;

   // seen_q is clear until the first strobe after reset, which forces that sample
   // to be kept whatever decim is. The >= compare lets a lowered decim take effect
   // on the very next strobe.
   assign keep = in_valid && (!seen_q || (cnt_q >= decim));

   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign push      = keep && (!fifo_full || pop);
   assign drop      = keep && fifo_full && !pop;

   always_comb begin
      cnt_d  = cnt_q;
      seen_d = seen_q;
      ovf_d  = ovf_q;
      if (in_valid) begin
         seen_d = 1'b1;
         cnt_d  = keep ? '0 : cnt_q + 1'b1;
      end
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         seen_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         seen_q <= seen_d;
         ovf_q  <= ovf_d;
      end
   end

   tqvp_vibhee_sync_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (in_data),
      .rd_en   (pop),
      .rd_data (out_data),
      .level   (level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign overflow = ovf_q;

endmodule
